pe_mac_unit: RTL and testbench

Systolic processing element that consumes the north/west operand streams driven by the PE stimulus bench. Each cycle it forwards the operands one hop south/east and multiply-accumulates their signed product into a BUS_WIDTH accumulator. A `clr` strobe restarts the dot product. The block is the tile replicated across the matrix-multiplier array.

---
 rtl/pe_mac_unit_if.sv | 24 ++
 rtl/pe_mac_unit.sv | 82 ++++++++
 tb/tb_pe_mac_unit.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/pe_mac_unit_if.sv
// Operand/result bundle for one systolic MAC tile.
// master drives operands and clr; slave is the processing element.
interface pe_mac_unit_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BUS_WIDTH  = 32
);
    logic signed [DATA_WIDTH-1:0] north_i;
    logic signed [DATA_WIDTH-1:0] west_i;
    logic                         clr;
    logic signed [DATA_WIDTH-1:0] south_o;
    logic signed [DATA_WIDTH-1:0] east_o;
    logic signed [BUS_WIDTH-1:0]  res_o;
    logic                         ouflow_o;

    modport master (
        output north_i, west_i, clr,
        input  south_o, east_o, res_o, ouflow_o
    );

    modport slave (
        input  north_i, west_i, clr,
        output south_o, east_o, res_o, ouflow_o
    );
endinterface

// File: rtl/pe_mac_unit.sv
// Systolic PE: forwards operands one hop south/east and accumulates their signed product.
// Define PE_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module pe_mac_unit #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BUS_WIDTH  = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    pe_mac_unit_if.slave bus
);
    localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;
    localparam logic signed [BUS_WIDTH-1:0] ACC_MAX = {1'b0, {(BUS_WIDTH-1){1'b1}}};
    localparam logic signed [BUS_WIDTH-1:0] ACC_MIN = {1'b1, {(BUS_WIDTH-1){1'b0}}};

    logic signed [DATA_WIDTH-1:0] a1;
    logic signed [DATA_WIDTH-1:0] b1;
    logic                         c1;
    logic signed [PROD_WIDTH-1:0] p2;
    logic                         c2;
    logic signed [BUS_WIDTH-1:0]  acc;
    logic                         ouflow;

    logic signed [PROD_WIDTH-1:0] a1_ext_c;
    logic signed [PROD_WIDTH-1:0] b1_ext_c;
    logic signed [BUS_WIDTH-1:0]  p2_ext_c;
    logic signed [BUS_WIDTH-1:0]  sum_c;
    logic signed [BUS_WIDTH-1:0]  acc_nxt_c;
    logic                         ovf_c;

    // Widen both operands first so the product is the full signed result.
    always_comb begin
        a1_ext_c = PROD_WIDTH'(a1);
        b1_ext_c = PROD_WIDTH'(b1);
    end

    // Accumulate step: overflow when equal-sign addends produce a sum of the other sign.
    always_comb begin
        p2_ext_c  = BUS_WIDTH'(p2);
        sum_c     = acc + p2_ext_c;
        ovf_c     = (acc[BUS_WIDTH-1] == p2_ext_c[BUS_WIDTH-1]) &&
                    (sum_c[BUS_WIDTH-1] != acc[BUS_WIDTH-1]);
        acc_nxt_c = sum_c;
`ifdef PE_SATURATE_EN
        if (ovf_c) begin
            acc_nxt_c = acc[BUS_WIDTH-1] ? ACC_MIN : ACC_MAX;
        end
`endif
    end

    // Three-stage pipeline; clr rides with its operands and acts at S3.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a1     <= '0;
            b1     <= '0;
            c1     <= 1'b0;
            p2     <= '0;
            c2     <= 1'b0;
            acc    <= '0;
            ouflow <= 1'b0;
        end else begin
            a1 <= bus.north_i;
            b1 <= bus.west_i;
            c1 <= bus.clr;
            p2 <= a1_ext_c * b1_ext_c;
            c2 <= c1;
            if (c2) begin
                acc    <= '0;
                ouflow <= 1'b0;
            end else begin
                acc <= acc_nxt_c;
                if (ovf_c) begin
                    ouflow <= 1'b1;
                end
            end
        end
    end

    assign bus.south_o  = a1;
    assign bus.east_o   = b1;
    assign bus.res_o    = acc;
    assign bus.ouflow_o = ouflow;
endmodule

// File: tb/tb_pe_mac_unit.sv
// Scoreboard bench for pe_mac_unit: a 32-bit and a 16-bit instance share one stimulus
// stream; an arithmetic reference model predicts forwarding and accumulator outputs.
module tb_pe_mac_unit;
    logic clk = 1'b0;
    logic rst;
    int   edge_cnt = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    pe_mac_unit_if #(.DATA_WIDTH(8), .BUS_WIDTH(32)) bus32 ();
    pe_mac_unit_if #(.DATA_WIDTH(8), .BUS_WIDTH(16)) bus16 ();

    pe_mac_unit #(.DATA_WIDTH(8), .BUS_WIDTH(32)) dut32 (
        .clk_i(clk), .rst_i(rst), .bus(bus32.slave)
    );
    pe_mac_unit #(.DATA_WIDTH(8), .BUS_WIDTH(16)) dut16 (
        .clk_i(clk), .rst_i(rst), .bus(bus16.slave)
    );

    typedef struct { int due; longint r32; bit o32; longint r16; bit o16; } mac_exp_t;
    typedef struct { int due; logic [7:0] s; logic [7:0] e; } fwd_exp_t;
    typedef struct { int due; string name; bit w16; longint val; bit of; } dir_exp_t;

    mac_exp_t mac_q[$];
    fwd_exp_t fwd_q[$];
    dir_exp_t dir_q[$];

    // Reference accumulator state for both widths.
    longint m32 = 0;
    longint m16 = 0;
    bit     mo32 = 1'b0;
    bit     mo16 = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @edge %0d: got %h, expected %h", name, edge_cnt, act, exp);
        end
    endfunction

    // Add p to a signed w-bit accumulator, following wrap or clamp semantics.
    task automatic acc_step(input int w, input longint a_in, input bit of_in, input longint p,
                            output longint a_out, output bit of_out);
        longint hi;
        longint lo;
        longint s;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -(longint'(1) << (w - 1));
        s = a_in + p;
        of_out = of_in;
        if (s > hi || s < lo) begin
            of_out = 1'b1;
`ifdef PE_SATURATE_EN
            s = (s > hi) ? hi : lo;
`else
            s = (s > hi) ? s - (longint'(1) << w) : s + (longint'(1) << w);
`endif
        end
        a_out = s;
    endtask

    // Present one operand pair (sampled at the next edge) and record what it must produce.
    task automatic drive(input int n, input int w, input int c, input int r);
        logic signed [7:0] ns;
        logic signed [7:0] ws;
        int k;
        ns = 8'(n);
        ws = 8'(w);
        bus32.north_i = ns; bus32.west_i = ws; bus32.clr = (c != 0);
        bus16.north_i = ns; bus16.west_i = ws; bus16.clr = (c != 0);
        rst = (r != 0);
        k = edge_cnt + 1;
        if (r != 0) begin
            fwd_q.push_back('{k, 8'h00, 8'h00});
            while (mac_q.size() > 0 && mac_q[$].due >= k) void'(mac_q.pop_back());
            m32 = 0; m16 = 0; mo32 = 1'b0; mo16 = 1'b0;
            for (int d = 0; d < 3; d++) mac_q.push_back('{k + d, 0, 1'b0, 0, 1'b0});
        end else begin
            fwd_q.push_back('{k, ns, ws});
            if (c != 0) begin
                m32 = 0; m16 = 0; mo32 = 1'b0; mo16 = 1'b0;
            end else begin
                acc_step(32, m32, mo32, longint'(ns) * longint'(ws), m32, mo32);
                acc_step(16, m16, mo16, longint'(ns) * longint'(ws), m16, mo16);
            end
            mac_q.push_back('{k + 2, m32, mo32, m16, mo16});
        end
        @(posedge clk);
        #1;
    endtask

    // Fixed expectation for the pair most recently sampled.
    task automatic expect_dir(input string name, input bit w16, input longint val, input bit of);
        dir_q.push_back('{edge_cnt + 2, name, w16, val, of});
    endtask

    always @(negedge clk) begin : monitor
        fwd_exp_t fe;
        mac_exp_t me;
        dir_exp_t de;
        while (fwd_q.size() > 0 && fwd_q[0].due <= edge_cnt) begin
            fe = fwd_q.pop_front();
            check("south32", {24'h0, bus32.south_o}, {24'h0, fe.s});
            check("east32",  {24'h0, bus32.east_o},  {24'h0, fe.e});
            check("south16", {24'h0, bus16.south_o}, {24'h0, fe.s});
            check("east16",  {24'h0, bus16.east_o},  {24'h0, fe.e});
        end
        while (mac_q.size() > 0 && mac_q[0].due <= edge_cnt) begin
            me = mac_q.pop_front();
            check("res32",    bus32.res_o, 32'(me.r32));
            check("ouflow32", {31'h0, bus32.ouflow_o}, {31'h0, me.o32});
            check("res16",    {16'h0, bus16.res_o}, {16'h0, 16'(me.r16)});
            check("ouflow16", {31'h0, bus16.ouflow_o}, {31'h0, me.o16});
        end
        while (dir_q.size() > 0 && dir_q[0].due <= edge_cnt) begin
            de = dir_q.pop_front();
            if (de.w16) begin
                check({de.name, "_res16"}, {16'h0, bus16.res_o}, {16'h0, 16'(de.val)});
                check({de.name, "_of16"}, {31'h0, bus16.ouflow_o}, {31'h0, de.of});
            end else begin
                check({de.name, "_res32"}, bus32.res_o, 32'(de.val));
                check({de.name, "_of32"}, {31'h0, bus32.ouflow_o}, {31'h0, de.of});
            end
        end
    end

    initial begin
        int waited;
        // Reset with random operands.
        drive(int'($urandom), int'($urandom), int'($urandom_range(0, 1)), 1);
        drive(int'($urandom), int'($urandom), int'($urandom_range(0, 1)), 1);
        drive(-1, 2, 0, 0);
        expect_dir("first_after_reset", 1'b0, -2, 1'b0);

        // Dot product, clear with held operands, second dot product.
        drive(int'($urandom), int'($urandom), 1, 0);
        drive(-1, 2, 0, 0); drive(-3, 4, 0, 0); drive(-5, 6, 0, 0); drive(-7, 8, 0, 0);
        expect_dir("dot_neg", 1'b0, -100, 1'b0);
        expect_dir("dot_neg", 1'b1, -100, 1'b0);
        drive(-7, 8, 1, 0);
        expect_dir("clr_held", 1'b0, 0, 1'b0);
        drive(11, 22, 0, 0); drive(33, 44, 0, 0); drive(55, 66, 0, 0); drive(77, 88, 0, 0);
        expect_dir("dot_pos", 1'b0, 12100, 1'b0);
        expect_dir("dot_pos", 1'b1, 12100, 1'b0);

        // Forwarding ramp with random clr.
        for (int i = 0; i <= 20; i++) drive(i, 20 - i, int'($urandom_range(0, 1)), 0);

        // 16-bit overflow, then clear.
        drive(0, 0, 1, 0);
        drive(127, 127, 0, 0); drive(127, 127, 0, 0); drive(127, 127, 0, 0);
`ifdef PE_SATURATE_EN
        expect_dir("ovf", 1'b1, 32767, 1'b1);
`else
        expect_dir("ovf", 1'b1, -17149, 1'b1);
`endif
        expect_dir("no_ovf", 1'b0, 48387, 1'b0);
        drive(127, 127, 1, 0);
        expect_dir("ovf_clr", 1'b1, 0, 1'b0);

        // Signed corner right after a clear.
        drive(-128, -128, 0, 0);
        expect_dir("min_sq", 1'b0, 16384, 1'b0);
        expect_dir("min_sq", 1'b1, 16384, 1'b0);

        // Mid-operation reset together with clr.
        drive(0, 0, 1, 0);
        drive(5, 5, 0, 0); drive(5, 5, 0, 0);
        drive(0, 0, 1, 1);
        drive(3, 3, 0, 0);
        expect_dir("after_reset", 1'b0, 9, 1'b0);
        expect_dir("after_reset", 1'b1, 9, 1'b0);

        // Random traffic with occasional clr and reset.
        repeat (400) drive(int'($urandom), int'($urandom),
                           int'($urandom_range(0, 15) == 0), int'($urandom_range(0, 63) == 0));

        repeat (4) drive(0, 0, 0, 0);
        waited = 0;
        while ((mac_q.size() > 0 || fwd_q.size() > 0 || dir_q.size() > 0) && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        @(negedge clk);
        #1;
        tests++;
        if (mac_q.size() > 0 || fwd_q.size() > 0 || dir_q.size() > 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0",
                     mac_q.size() + fwd_q.size() + dir_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
